// File: rtl/rformat_sequencer.sv
// rformat_sequencer: Moore control sequencer for the bus datapath. It runs the
// instruction fetch (T0-T2), then the R-format execute steps (T3-T6) for ALU,
// single-operand and mul/div instructions, and traps illegal opcodes.
//
// Ports:
//   clock        system clock, rising-edge active
//   clear        asynchronous active-low reset
//   run          level request to keep executing instructions
//   mem_ready    memory data valid, sampled while in T1
//   ir           instruction register contents fed back from the datapath
//   reg_out      one-hot register-to-bus enables
//   reg_in       one-hot register load enables
//   PCout..read  single-bit datapath enables, same names as the datapath
//   alu_op       ALU operation select (opcode while executing, else 0)
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse in the final writeback cycle
//   illegal      one-cycle pulse when an illegal opcode is trapped
//   instr_count  retired legal instruction count, wraps
module rformat_sequencer #(
    parameter int unsigned         NUM_REGS   = 16,
    parameter int unsigned         OPW        = 5,
    parameter logic [2**OPW-1:0]   LEGAL_MASK = 32'h0000_C1F8,
    parameter logic [OPW-1:0]      MUL_OP     = 5'b01110,
    parameter logic [OPW-1:0]      DIV_OP     = 5'b01111,
    parameter logic [OPW-1:0]      NEG_OP     = 5'b10000,
    parameter logic [OPW-1:0]      NOT_OP     = 5'b10001,
    parameter int unsigned         CNT_W      = 16
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [31:0]         ir,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic                PCout,
    output logic                PCin,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zlowin,
    output logic                Zhighin,
    output logic                ZLOout,
    output logic                ZHIout,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                read,
    output logic [OPW-1:0]      alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int unsigned RIDX_W = $clog2(NUM_REGS);
    localparam int unsigned RA_HI  = 31 - OPW;
    localparam int unsigned RB_HI  = RA_HI - RIDX_W;
    localparam int unsigned RC_HI  = RB_HI - RIDX_W;
    localparam int unsigned LSB_HI = RC_HI - RIDX_W;

    typedef enum logic [2:0] {
        StIdle,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6
    } state_e;

    state_e state_q, state_d;

    // IR field decode
    logic [OPW-1:0]      op;
    logic [RIDX_W-1:0]   ra, rb, rc;
    logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;
    logic                is_legal, is_single, is_wide, is_final;
    logic                unused_ir;

    assign op        = ir[31 -: OPW];
    assign ra        = ir[RA_HI -: RIDX_W];
    assign rb        = ir[RB_HI -: RIDX_W];
    assign rc        = ir[RC_HI -: RIDX_W];
    assign unused_ir = ^ir[LSB_HI:0];

    assign ra_oh = {{(NUM_REGS-1){1'b0}}, 1'b1} << ra;
    assign rb_oh = {{(NUM_REGS-1){1'b0}}, 1'b1} << rb;
    assign rc_oh = {{(NUM_REGS-1){1'b0}}, 1'b1} << rc;

    assign is_legal  = LEGAL_MASK[op];
    assign is_single = (op == NEG_OP) || (op == NOT_OP);
    assign is_wide   = (op == MUL_OP) || (op == DIV_OP);
    assign is_final  = ((state_q == StT5) && !is_wide) || (state_q == StT6);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (run) state_d = StT0;
            StT0:   state_d = StT1;
            StT1:   if (mem_ready) state_d = StT2;
            StT2:   state_d = StT3;
            StT3: begin
                if (!is_legal)      state_d = StIdle;
                else if (is_single) state_d = StT5;
                else                state_d = StT4;
            end
            StT4:   state_d = StT5;
            StT5: begin
                if (is_wide) state_d = StT6;
                else         state_d = run ? StT0 : StIdle;
            end
            StT6:   state_d = run ? StT0 : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Registered parts of the outputs that T3 also drives
    logic [NUM_REGS-1:0] reg_out_q;
    logic                zlowin_q;
    logic [OPW-1:0]      alu_op_q;

    // Outputs are decoded from the state being entered, so each enable is
    // registered and valid for the whole cycle of its state. The decode for
    // T4..T6 reads ir while in T3..T5, after IR has been loaded.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= StIdle;
            reg_out_q   <= '0;
            reg_in      <= '0;
            PCout       <= 1'b0;
            PCin        <= 1'b0;
            MARin       <= 1'b0;
            MDRin       <= 1'b0;
            MDRout      <= 1'b0;
            IRin        <= 1'b0;
            zlowin_q    <= 1'b0;
            Zhighin     <= 1'b0;
            ZLOout      <= 1'b0;
            ZHIout      <= 1'b0;
            HIin        <= 1'b0;
            LOin        <= 1'b0;
            IncPC       <= 1'b0;
            read        <= 1'b0;
            alu_op_q    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q   <= state_d;
            if (is_final) instr_count <= instr_count + 1'b1;

            PCout     <= (state_d == StT0);
            MARin     <= (state_d == StT0);
            IncPC     <= (state_d == StT0);
            zlowin_q  <= (state_d == StT0) || (state_d == StT4);
            ZLOout    <= (state_d == StT1) || (state_d == StT5);
            PCin      <= (state_d == StT1);
            read      <= (state_d == StT1);
            MDRin     <= (state_d == StT1);
            MDRout    <= (state_d == StT2);
            IRin      <= (state_d == StT2);
            reg_out_q <= (state_d == StT4) ? rc_oh : '0;
            Zhighin   <= (state_d == StT4) && is_wide;
            LOin      <= (state_d == StT5) && is_wide;
            reg_in    <= ((state_d == StT5) && !is_wide) ? ra_oh : '0;
            ZHIout    <= (state_d == StT6);
            HIin      <= (state_d == StT6);
            done      <= ((state_d == StT5) && !is_wide) || (state_d == StT6);
            alu_op_q  <= ((state_d == StT4) || (state_d == StT5) || (state_d == StT6))
                         ? op : '0;
            busy      <= (state_d != StIdle);
        end
    end

    // IR only becomes valid on the edge that enters T3, so the T3 enables are
    // decoded from the registered state and the registered IR during T3.
    logic in_t3, t3_exec;

    assign in_t3   = (state_q == StT3);
    assign t3_exec = in_t3 && is_legal;

    assign reg_out = reg_out_q | (t3_exec ? rb_oh : '0);
    assign Yin     = t3_exec && !is_single;
    assign Zlowin  = zlowin_q | (t3_exec && is_single);
    assign alu_op  = t3_exec ? op : alu_op_q;
    assign illegal = in_t3 && !is_legal;

endmodule

// File: tb/tb_rformat_sequencer.sv
module tb_rformat_sequencer;

    // Opcodes 16/17 (NEG/NOT) are enabled here so the single-operand path runs;
    // opcode 31 stays illegal.
    localparam logic [31:0] MASK = 32'h0003_C1F8;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        run   = 1'b0;
    logic        mem_ready;
    logic [31:0] ir_q  = '0;

    logic [15:0] reg_out, reg_in;
    logic        PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin;
    logic        ZLOout, ZHIout, HIin, LOin, IncPC, read, busy, done, illegal;
    logic [4:0]  alu_op;
    logic [15:0] instr_count;

    always #5 clock = ~clock;

    rformat_sequencer #(.LEGAL_MASK(MASK)) dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir_q),
        .reg_out(reg_out), .reg_in(reg_in), .PCout(PCout), .PCin(PCin), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
        .Zhighin(Zhighin), .ZLOout(ZLOout), .ZHIout(ZHIout), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .read(read), .alu_op(alu_op), .busy(busy), .done(done),
        .illegal(illegal), .instr_count(instr_count)
    );

    // ---------------- datapath and memory model ----------------
    logic [31:0] rf [16] = '{default: '0};
    logic [31:0] pc = '0, mar = '0, mdr = '0, y = '0, hi = '0, lo = '0;
    logic [63:0] z = '0;
    logic [31:0] bus;
    logic [63:0] alu;
    logic [31:0] prog [16];
    int          prog_wait [16];
    int          rd_cycles = 0;
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    always_comb begin
        bus = '0;
        for (int i = 0; i < 16; i++) if (reg_out[i]) bus = bus | rf[i];
        if (PCout)  bus = bus | pc;
        if (ZLOout) bus = bus | z[31:0];
        if (ZHIout) bus = bus | z[63:32];
        if (MDRout) bus = bus | mdr;
    end

    always_comb begin
        if (IncPC) alu = {32'b0, bus + 32'd1};
        else case (alu_op)
            5'd6:  alu = {32'b0, y | bus};
            5'd14: alu = {32'b0, y} * {32'b0, bus};
            5'd16: alu = {32'b0, 32'd0 - bus};
            5'd17: alu = {32'b0, ~bus};
            default: alu = {32'b0, y + bus};
        endcase
    end

    always_comb mem_ready = read && (rd_cycles >= prog_wait[mar[3:0]]);

    always @(posedge clock) begin
        if (pl_en) rf[pl_idx] <= pl_val;
        for (int i = 0; i < 16; i++) if (reg_in[i]) rf[i] <= bus;
        if (PCin)          pc <= bus;
        if (MARin)         mar <= bus;
        if (MDRin && read) mdr <= prog[mar[3:0]];
        if (IRin)          ir_q <= bus;
        if (Yin)           y <= bus;
        if (Zlowin)        z[31:0] <= alu[31:0];
        if (Zhighin)       z[63:32] <= alu[63:32];
        if (HIin)          hi <= bus;
        if (LOin)          lo <= bus;
        rd_cycles <= read ? rd_cycles + 1 : 0;
    end

    // ---------------- expected-trace model ----------------
    typedef struct packed {
        logic [15:0] rout;
        logic [15:0] rin;
        logic pcout, pcin, marin, mdrin, mdrout, irin, yin, zlowin, zhighin;
        logic zloout, zhiout, hiin, loin, incpc, rd;
        logic [4:0]  alu;
        logic busy, done, illegal;
        logic [15:0] cnt;
    } ctl_t;

    ctl_t        act;
    ctl_t        exp_q [$];
    logic [15:0] exp_cnt = '0;
    int          n_chk = 0, n_fail = 0, n_cyc = 0;

    always_comb begin
        act = '0;
        act.rout = reg_out; act.rin = reg_in;
        act.pcout = PCout; act.pcin = PCin; act.marin = MARin; act.mdrin = MDRin;
        act.mdrout = MDRout; act.irin = IRin; act.yin = Yin; act.zlowin = Zlowin;
        act.zhighin = Zhighin; act.zloout = ZLOout; act.zhiout = ZHIout; act.hiin = HIin;
        act.loin = LOin; act.incpc = IncPC; act.rd = read; act.alu = alu_op;
        act.busy = busy; act.done = done; act.illegal = illegal; act.cnt = instr_count;
    end

    function automatic ctl_t busy_ctl();
        ctl_t c;
        c = '0;
        c.busy = 1'b1;
        c.cnt = exp_cnt;
        return c;
    endfunction

    function automatic ctl_t idle_ctl();
        ctl_t c;
        c = '0;
        c.cnt = exp_cnt;
        return c;
    endfunction

    // Appends the per-cycle control vectors one instruction must produce.
    task automatic push_instr(input logic [31:0] w, input int waits, input bit trail_idle,
                              input bit cut_t4);
        logic [31:0] m;
        logic [4:0]  op;
        int          ra, rb, rc;
        bit          legal, single, wide;
        ctl_t        c;
        m      = MASK;
        op     = 5'(w >> 27);
        ra     = int'((w >> 23) & 32'hF);
        rb     = int'((w >> 19) & 32'hF);
        rc     = int'((w >> 15) & 32'hF);
        legal  = m[op];
        single = (op == 5'd16) || (op == 5'd17);
        wide   = (op == 5'd14) || (op == 5'd15);

        c = busy_ctl(); c.pcout = 1; c.marin = 1; c.incpc = 1; c.zlowin = 1;
        exp_q.push_back(c);
        for (int i = 0; i <= waits; i++) begin
            c = busy_ctl(); c.zloout = 1; c.pcin = 1; c.rd = 1; c.mdrin = 1;
            exp_q.push_back(c);
        end
        c = busy_ctl(); c.mdrout = 1; c.irin = 1;
        exp_q.push_back(c);
        if (!legal) begin
            c = busy_ctl(); c.illegal = 1;
            exp_q.push_back(c);
            exp_q.push_back(idle_ctl());
            return;
        end
        c = busy_ctl(); c.rout[rb] = 1'b1; c.alu = op;
        if (single) c.zlowin = 1; else c.yin = 1;
        exp_q.push_back(c);
        if (!single) begin
            c = busy_ctl(); c.rout[rc] = 1'b1; c.alu = op; c.zlowin = 1; c.zhighin = wide;
            exp_q.push_back(c);
            if (cut_t4) return;
        end
        c = busy_ctl(); c.zloout = 1; c.alu = op;
        if (wide) c.loin = 1;
        else begin c.rin[ra] = 1'b1; c.done = 1; end
        exp_q.push_back(c);
        if (wide) begin
            c = busy_ctl(); c.zhiout = 1; c.hiin = 1; c.done = 1; c.alu = op;
            exp_q.push_back(c);
        end
        exp_cnt = exp_cnt + 16'd1;
        if (trail_idle) exp_q.push_back(idle_ctl());
    endtask

    // Compare process: one expected vector per cycle while the trace is non-empty.
    initial begin
        ctl_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_chk++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL ctl_cycle_%0d: got %h required %h", n_cyc, act, e);
                end
                n_cyc++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic check_ctl(input string name, input ctl_t got, input ctl_t want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock); #1;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL trace_drain: %0d vectors left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clock);
        pl_idx = idx; pl_val = val; pl_en = 1'b1;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    // Single instruction; run is dropped during T0 and must not abort it.
    task automatic one_instr(input logic [31:0] w, input int waits);
        @(negedge clock); #2;
        push_instr(w, waits, 1'b1, 1'b0);
        run = 1'b1;
        @(posedge clock); #2;
        run = 1'b0;
        drain();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 16; i++) begin
            prog[i] = '0;
            prog_wait[i] = 0;
        end
        prog[0] = 32'h3091_8000;                        // OR  R1 = R2 | R3
        prog[1] = 32'h3211_8000; prog_wait[1] = 3;      // OR  R4 = R2 | R3, slow memory
        prog[2] = 32'h7091_8000;                        // MUL HI:LO = R2 * R3
        prog[3] = 32'h8890_0000;                        // NOT R1 = ~R2
        prog[4] = 32'hF891_8000;                        // opcode 31, illegal
        prog[5] = 32'h3291_8000;                        // OR  R5 = R2 | R3
        prog[6] = 32'h8318_0000;                        // NEG R6 = -R3
        prog[7] = 32'h3391_8000;                        // OR  R7 = R2 | R3, aborted

        repeat (3) @(negedge clock);
        check_ctl("reset_outputs", act, '0);
        #2 clear = 1'b1;

        preload(4'd2, 32'h12);
        preload(4'd3, 32'h14);
        one_instr(prog[0], 0);
        check32("or_r1", rf[1], 32'h16);
        check32("count_after_or", 32'(instr_count), 32'd1);

        one_instr(prog[1], 3);
        check32("or_wait_r4", rf[4], 32'h16);
        check32("count_after_wait", 32'(instr_count), 32'd2);

        preload(4'd2, 32'd3);
        preload(4'd3, 32'd5);
        one_instr(prog[2], 0);
        check32("mul_lo", lo, 32'd15);
        check32("mul_hi", hi, 32'd0);
        check32("mul_no_reg_write", rf[1], 32'h16);
        check32("count_after_mul", 32'(instr_count), 32'd3);

        one_instr(prog[3], 0);
        check32("not_r1", rf[1], 32'hFFFF_FFFC);

        one_instr(prog[4], 0);
        check32("count_after_illegal", 32'(instr_count), 32'd4);
        check32("illegal_no_write", rf[1], 32'hFFFF_FFFC);

        // Back-to-back issue with reset pulsed in T4 of the third instruction.
        preload(4'd7, 32'hA5);
        @(negedge clock); #2;
        push_instr(prog[5], 0, 1'b0, 1'b0);
        push_instr(prog[6], 0, 1'b0, 1'b0);
        push_instr(prog[7], 0, 1'b0, 1'b1);
        run = 1'b1;
        drain();
        clear = 1'b0;
        run = 1'b0;
        #1;
        check_ctl("clear_async_outputs", act, '0);
        exp_cnt = '0;
        repeat (2) @(negedge clock);
        #2 clear = 1'b1;
        repeat (3) @(negedge clock);
        check_ctl("idle_after_clear", act, '0);
        check32("count_after_clear", 32'(instr_count), 32'd0);
        check32("chain_r5", rf[5], 32'd7);
        check32("chain_neg_r6", rf[6], 32'hFFFF_FFFB);
        check32("aborted_r7", rf[7], 32'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

endmodule
